// File: rtl/mfcc_frame_rx_if.sv
// rtl/mfcc_frame_rx_if.sv - coefficient stream and frame read-port bundle for mfcc_frame_rx
//
// Producer side : dv_i, x_i, idx_i, vad_i (one indexed coefficient per cycle)
// Consumer side : frame_valid, frame_vad, rd_addr, rd_data, frame_done
// slave modport is the receiver (mfcc_frame_rx); master modport drives it.
interface mfcc_frame_rx_if #(
    parameter int DW = 26,
    parameter int AW = 5
) ();
    logic                 dv_i;
    logic signed [DW-1:0] x_i;
    logic [AW-1:0]        idx_i;
    logic                 vad_i;
    logic                 frame_valid;
    logic                 frame_vad;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;
    logic                 frame_done;

    modport slave (
        input  dv_i, x_i, idx_i, vad_i, rd_addr, frame_done,
        output frame_valid, frame_vad, rd_data
    );

    modport master (
        output dv_i, x_i, idx_i, vad_i, rd_addr, frame_done,
        input  frame_valid, frame_vad, rd_data
    );
endinterface

// File: rtl/mfcc_frame_rx.sv
// rtl/mfcc_frame_rx.sv - MFCC frame receiver with index checking and ping-pong frame buffer
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : coefficient stream in, frame valid/done handshake and read port out
//   seq_err      : one-cycle pulse on an index/ordering error
//   seq_err_cnt  : saturating count of seq_err pulses
//   drop_cnt     : saturating count of frames dropped because both banks were full
module mfcc_frame_rx #(
    parameter int NCOEF = 12,
    parameter int DW    = 26,
    parameter int AW    = 5,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mfcc_frame_rx_if.slave bus,
    output logic          seq_err,
    output logic [CW-1:0] seq_err_cnt,
    output logic [CW-1:0] drop_cnt
);
    localparam int            IW     = $clog2(NCOEF);
    localparam logic [AW-1:0] LAST   = AW'(NCOEF - 1);
    localparam logic [AW-1:0] NCOEFA = AW'(NCOEF);

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    wr_state_t      r_state;
    logic [AW-1:0]  r_cnt;
    logic [1:0]     r_full;
    logic [1:0]     r_vad;
    logic           r_wr_bank;
    logic           r_rd_bank;
    logic           r_frame_valid;
    logic           r_frame_vad;
    logic [DW-1:0]  r_rd_data;
    logic           r_seq_err;
    logic [CW-1:0]  r_seq_err_cnt;
    logic [CW-1:0]  r_drop_cnt;
    logic [DW-1:0]  r_mem [2][NCOEF];

    logic           w_we;
    logic           w_err;
    logic           w_drop;
    logic           w_last;
    logic           w_rel;
    logic [IW-1:0]  w_widx;

    // Write-side events decoded from the current state and stream inputs.
    always_comb begin
        w_we   = 1'b0;
        w_err  = 1'b0;
        w_drop = 1'b0;
        w_widx = bus.idx_i[IW-1:0];
        case (r_state)
            IDLE: begin
                if (bus.dv_i) begin
                    if (bus.idx_i != '0)       w_err  = 1'b1;
                    else if (r_full[r_wr_bank]) w_drop = 1'b1;
                    else                        w_we   = 1'b1;
                end
            end
            FILL: begin
                if (!bus.dv_i)                 w_err = 1'b1;
                else if (bus.idx_i != r_cnt)   w_err = 1'b1;
                else                           w_we  = 1'b1;
            end
            default: ;
        endcase
        w_last = (r_state == FILL) && w_we && (r_cnt == LAST);
        // A release is honoured only against a frame the consumer can see.
        w_rel  = bus.frame_done && r_frame_valid;
    end

    // Storage needs no reset: a bank is only readable once fully written.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_bank][w_widx] <= bus.x_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_full        <= '0;
            r_vad         <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_vad   <= 1'b0;
            r_rd_data     <= '0;
            r_seq_err     <= 1'b0;
            r_seq_err_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_seq_err <= w_err;
            if (w_err && (r_seq_err_cnt != '1)) r_seq_err_cnt <= r_seq_err_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != '1))   r_drop_cnt    <= r_drop_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_err || w_drop) begin
                        r_state <= DROP;
                    end else if (w_we) begin
                        r_cnt   <= AW'(1);
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!bus.dv_i) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_err) begin
                        r_cnt   <= '0;
                        r_state <= DROP;
                    end else if (w_last) begin
                        r_full[r_wr_bank] <= 1'b1;
                        r_vad[r_wr_bank]  <= bus.vad_i;
                        r_wr_bank         <= ~r_wr_bank;
                        r_cnt             <= '0;
                        r_state           <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!bus.dv_i) r_state <= IDLE;
                end
            endcase

            // Completion always targets the free write bank and a release the
            // full read bank, so both bit updates can land in the same cycle.
            if (w_rel) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_frame_valid     <= 1'b0;
                r_frame_vad       <= 1'b0;
            end else begin
                r_frame_valid <= r_full[r_rd_bank];
                r_frame_vad   <= r_vad[r_rd_bank];
            end

            if (bus.rd_addr < NCOEFA) r_rd_data <= r_mem[r_rd_bank][bus.rd_addr[IW-1:0]];
            else                      r_rd_data <= '0;
        end
    end

    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_vad   = r_frame_vad;
    assign bus.rd_data     = r_rd_data;
    assign seq_err         = r_seq_err;
    assign seq_err_cnt     = r_seq_err_cnt;
    assign drop_cnt        = r_drop_cnt;
endmodule

// File: tb/tb_mfcc_frame_rx.sv
// tb/tb_mfcc_frame_rx.sv - directed self-checking bench for mfcc_frame_rx
module tb_mfcc_frame_rx;
    localparam int NCOEF = 12;
    localparam int DW    = 26;
    localparam int AW    = 5;
    localparam int CW    = 8;

    logic          clk;
    logic          rst_n;
    logic          seq_err;
    logic [CW-1:0] seq_err_cnt;
    logic [CW-1:0] drop_cnt;

    int n_checks;
    int n_fails;

    mfcc_frame_rx_if #(.DW(DW), .AW(AW)) bus ();

    mfcc_frame_rx #(.NCOEF(NCOEF), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .seq_err     (seq_err),
        .seq_err_cnt (seq_err_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dv_i  = 1'b0;
        bus.idx_i = '0;
        bus.vad_i = 1'b0;
    endtask

    // Drives indices first..last back to back, x = base + mul*idx, vad on the last word.
    task automatic send_frame(input int base, input int mul, input int first, input int last,
                              input logic vad);
        for (int i = first; i <= last; i++) begin
            bus.dv_i  = 1'b1;
            bus.idx_i = AW'(i);
            bus.x_i   = DW'(base + mul * i);
            bus.vad_i = (i == last) ? vad : 1'b0;
            tick();
        end
    endtask

    task automatic release_frame();
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
    endtask

    task automatic read(input int addr);
        bus.rd_addr = AW'(addr);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n          = 1'b0;
        bus.x_i        = '0;
        bus.rd_addr    = '0;
        bus.frame_done = 1'b0;
        idle();
        tick();
        tick();
        check("rst_frame_valid", bus.frame_valid, 0);
        check("rst_frame_vad", bus.frame_vad, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_seq_err_cnt", seq_err_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Clean frame, x = 100*idx + 1, vad on idx 11 -> bank 0.
        send_frame(1, 100, 0, 11, 1'b1);
        idle();
        check("t1_valid_one_after", bus.frame_valid, 0);
        tick();
        check("t1_valid_two_after", bus.frame_valid, 1);
        check("t1_vad", bus.frame_vad, 1);
        read(5);
        check("t1_rd5", bus.rd_data, 501);
        check("t1_no_seq_err", seq_err_cnt, 0);

        // Release it, then three back-to-back frames: two held, third dropped.
        release_frame();
        send_frame(1000, 1, 0, 11, 1'b0);
        send_frame(2000, 1, 0, 11, 1'b1);
        send_frame(7000, 1, 0, 11, 1'b1);
        idle();
        tick();
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_seq_err_cnt", seq_err_cnt, 0);
        check("t2_valid_f1", bus.frame_valid, 1);
        check("t2_vad_f1", bus.frame_vad, 0);
        read(3);
        check("t2_rd_f1", bus.rd_data, 1003);
        release_frame();
        check("t2_valid_low", bus.frame_valid, 0);
        tick();
        check("t2_valid_f2", bus.frame_valid, 1);
        check("t2_vad_f2", bus.frame_vad, 1);
        read(11);
        check("t2_rd_f2", bus.rd_data, 2011);
        read(12);
        check("t2_rd_oob", bus.rd_data, 0);
        release_frame();
        tick();
        tick();
        check("t2_empty", bus.frame_valid, 0);

        // Indices 0,1,2,4 -> error at idx 4, nothing stored.
        send_frame(0, 1, 0, 2, 1'b0);
        bus.dv_i  = 1'b1;
        bus.idx_i = AW'(4);
        tick();
        check("t3_seq_err", seq_err, 1);
        check("t3_seq_err_cnt", seq_err_cnt, 1);
        idle();
        tick();
        check("t3_seq_err_pulse", seq_err, 0);
        tick();
        check("t3_no_frame", bus.frame_valid, 0);
        send_frame(3000, 1, 0, 11, 1'b0);
        idle();
        tick();
        check("t3_clean_valid", bus.frame_valid, 1);
        read(0);
        check("t3_clean_rd0", bus.rd_data, 3000);
        release_frame();
        tick();

        // Short frame (dv drops after idx 6), then a frame starting at idx 3.
        send_frame(0, 1, 0, 6, 1'b0);
        idle();
        tick();
        check("t4_gap_seq_err", seq_err, 1);
        check("t4_gap_cnt", seq_err_cnt, 2);
        tick();
        check("t4_gap_no_frame", bus.frame_valid, 0);
        bus.dv_i  = 1'b1;
        bus.idx_i = AW'(3);
        tick();
        check("t4_bad_start", seq_err, 1);
        check("t4_bad_start_cnt", seq_err_cnt, 3);
        bus.idx_i = AW'(4);
        tick();
        check("t4_drop_quiet", seq_err, 0);
        idle();
        tick();

        // Reset while one frame is readable and another is half written.
        send_frame(4000, 1, 0, 11, 1'b1);
        idle();
        tick();
        check("t5_valid_before", bus.frame_valid, 1);
        send_frame(6000, 1, 0, 6, 1'b0);
        bus.dv_i  = 1'b1;
        bus.idx_i = AW'(7);
        rst_n     = 1'b0;
        #1;
        check("t5_rst_valid", bus.frame_valid, 0);
        check("t5_rst_vad", bus.frame_vad, 0);
        check("t5_rst_seq_err_cnt", seq_err_cnt, 0);
        check("t5_rst_drop_cnt", drop_cnt, 0);
        check("t5_rst_rd_data", bus.rd_data, 0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(5000, 1, 0, 11, 1'b0);
        idle();
        tick();
        check("t5_after_valid", bus.frame_valid, 1);
        read(7);
        check("t5_after_rd7", bus.rd_data, 5007);
        release_frame();
        tick();
        tick();
        check("t5_bank1_clear", bus.frame_valid, 0);

        // 300 bad single-word frames -> counter saturates.
        for (int k = 0; k < 300; k++) begin
            bus.dv_i  = 1'b1;
            bus.idx_i = AW'(1);
            tick();
            idle();
            tick();
        end
        check("t6_sat", seq_err_cnt, 255);
        check("t6_drop_cnt", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mfcc_frame_rx.md
Name: mfcc_frame_rx

Overview:
- Receiving end of the MFCC coefficient stream.
- Accepts the per-frame burst of indexed cepstral coefficients (dv/index/data) and checks index ordering.
- Assembles complete frames into a two-bank ping-pong buffer.
- Presents each completed frame, with its VAD flag, to the downstream HMM/Viterbi scorer through a valid/done handshake and a random-access read port.

Parameters:
- NCOEF, 12, coefficients per frame; expected indices are 0..NCOEF-1.
- DW, 26, signed coefficient width.
- AW, 5, index/read-address width.
- CW, 8, width of the saturating error/drop counters.

Ports:
- clk  in  1  global clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- dv_i  in  1  coefficient valid; high for NCOEF consecutive cycles per frame.
- x_i  in  DW  signed coefficient.
- idx_i  in  AW  coefficient index.
- vad_i  in  1  voice-activity flag for the frame, sampled with the last coefficient.
- frame_valid  out  1  a complete frame is readable.
- frame_vad  out  1  VAD flag of the readable frame.
- rd_addr  in  AW  coefficient read address.
- rd_data  out  DW  coefficient at rd_addr, 1-cycle latency.
- frame_done  in  1  one-cycle pulse; consumer releases the current frame.
- seq_err  out  1  one-cycle pulse on an index or ordering error.
- seq_err_cnt  out  CW  saturating count of seq_err pulses.
- drop_cnt  out  CW  saturating count of frames dropped because both banks were full.

Behaviour:
- Reset (async assert, sync release):
  - full[1:0]=0, wr_bank=0, rd_bank=0, write state IDLE, cnt=0.
  - All outputs 0.
- Storage: 2 banks x NCOEF x DW, registers or distributed RAM.
- Write FSM, states IDLE, FILL, DROP:
  - IDLE, dv_i=0: stay.
  - IDLE, dv_i=1, idx_i!=0: seq_err pulse, go DROP.
  - IDLE, dv_i=1, idx_i=0, full[wr_bank]=1: drop_cnt+1, go DROP. No seq_err.
  - IDLE, dv_i=1, idx_i=0, bank free: write bank[wr_bank][0], cnt=1, go FILL.
  - FILL, dv_i=1, idx_i==cnt: write the word, cnt+1.
  - FILL, write with cnt==NCOEF-1: set full[wr_bank], latch vad_i into that bank's vad bit, toggle wr_bank, go IDLE.
  - FILL, dv_i=1, idx_i!=cnt: seq_err pulse, discard partial frame (bank stays free), go DROP.
  - FILL, dv_i=0 (gap or short frame): seq_err pulse, discard, go IDLE.
  - DROP: ignore data until dv_i=0, then IDLE.
  - Extra coefficients after a completed frame arrive in IDLE with idx_i!=0 and raise seq_err.
- Read side:
  - frame_valid = full[rd_bank], registered.
  - frame_vad = vad bit of rd_bank.
  - frame_done while frame_valid=1: clear full[rd_bank], toggle rd_bank.
  - After frame_done, frame_valid drops for at least one cycle, then rises again if the other bank is full.
  - frame_done while frame_valid=0: ignored.
- rd_data:
  - Registered; reflects bank[rd_bank][rd_addr] one cycle after rd_addr is presented.
  - rd_addr >= NCOEF returns 0.
  - Contents are stable while frame_valid=1.
- Simultaneous events:
  - Frame completion on one bank and frame_done on the other in the same cycle: both take effect.
  - A bank released by frame_done is writable from the next cycle.
- Counters: seq_err_cnt and drop_cnt saturate at 2^CW-1 and never wrap.
- Reset mid-frame: partial data is discarded; the next frame starts at idx 0 into bank 0.
- Data is stored bit-exact with no arithmetic. The producer's lower DW bits map directly to x_i.

Test Plan:
- Frame idx 0..11 with x=100*idx+1, vad_i=1 at idx 11 -> frame_valid=1 two cycles after the last dv; rd_addr=5 gives rd_data=501; frame_vad=1; no seq_err.
- Three back-to-back frames, no frame_done -> frames 1 and 2 held; frame 3 gives drop_cnt=1. After frame_done, frame 2 data readable; frame_valid returns 1 after its one-cycle low.
- Frame with indices 0,1,2,4 -> seq_err pulse at idx 4, seq_err_cnt=1, frame_valid stays 0. The next clean frame is accepted into the same bank.
- dv_i dropped after idx 6 -> seq_err=1, no frame stored. Frame starting at idx 3 -> seq_err, DROP until dv_i low.
- rst_n asserted at idx 7 of a frame and during frame_valid -> all outputs 0 immediately. A following clean frame lands in bank 0 with correct data.
- 300 bad frames -> seq_err_cnt saturates at 255.
